// File: rtl/mem_bus_responder.sv
// mem_bus_responder: slave end of the core bus holding a line-organised store; serves one
// line read/write at a time and returns a single-cycle response after a fixed latency.
module mem_bus_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 4,
  parameter int ID_WIDTH   = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req_read,
  input  logic                  i_req_write,
  input  logic [ID_WIDTH-1:0]   i_req_id,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [LINE_WIDTH-1:0] i_req_data,
  output logic                  o_rsp_valid,
  output logic [ID_WIDTH-1:0]   o_rsp_id,
  output logic [ADDR_WIDTH-1:0] o_rsp_addr,
  output logic [LINE_WIDTH-1:0] o_rsp_data,
  output logic                  o_busy
);
  localparam int OFF = $clog2(LINE_WIDTH / 8);
  localparam int IW  = $clog2(DEPTH);
  localparam int CW  = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] AMASK = {ADDR_WIDTH{1'b1}} << OFF;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND, S_COOLDOWN} state_t;
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_wr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_data;
  logic [LINE_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_req;
  logic [IW-1:0]         w_idx;
  logic                  w_commit;
  assign w_req    = i_req_read | i_req_write;
  assign w_idx    = r_addr[OFF +: IW];
  assign w_commit = r_state == S_RESPOND && r_wr;
  // Store has no reset; an async reset before the RESPOND edge leaves r_state idle, so no write.
  always_ff @(posedge i_clock)
    if (w_commit) r_mem[w_idx] <= r_data;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_id        <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_addr  <= '0;
      o_rsp_data  <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_busy      <= r_state != S_IDLE || w_req;
      case (r_state)
        S_IDLE: if (w_req) begin
          r_wr    <= i_req_write;
          r_id    <= i_req_id;
          r_addr  <= i_req_addr & AMASK;
          r_data  <= i_req_data;
          r_cnt   <= CW'(LATENCY - 1);
          r_state <= LATENCY > 1 ? S_WAIT : S_RESPOND;
        end
        S_WAIT: begin
          r_cnt   <= r_cnt - CW'(1);
          r_state <= r_cnt == CW'(1) ? S_RESPOND : S_WAIT;
        end
        S_RESPOND: begin
          o_rsp_valid <= 1'b1;
          o_rsp_id    <= r_id;
          o_rsp_addr  <= r_addr;
          o_rsp_data  <= r_wr ? r_data : r_mem[w_idx];
          r_state     <= S_COOLDOWN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the core memory bus: the slave end of the core bus request interface and the master end of the core bus response interface.
- Holds a line-organised backing store and serves one outstanding line read or line write at a time.
- Returns a single-cycle response after a fixed, programmable latency.
- Sits outside the core, where it replaces the behavioural memory for synthesis and simulation; the request `id` is echoed on the response so the core can route it to the icache or dcache.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the bus.
- LINE_WIDTH, 128, data bits per transfer; a power of 2 and at least 8.
- DEPTH, 256, number of lines in the store; a power of 2.
- LATENCY, 4, cycles from request acceptance to response; must be at least 1.
- ID_WIDTH, 1, width of the requester tag.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low: asserted when 0.
- req_read  in  1  read request; held by the master until the response.
- req_write  in  1  write request; held by the master until the response.
- req_id  in  ID_WIDTH  requester tag.
- req_addr  in  ADDR_WIDTH  byte address.
- req_data  in  LINE_WIDTH  write line data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  ID_WIDTH  echoed tag.
- rsp_addr  out  ADDR_WIDTH  echoed byte address, line-aligned.
- rsp_data  out  LINE_WIDTH  line read data; for writes, the data just written.
- busy  out  1  high from request acceptance through the cooldown cycle.

Behaviour:
- Line index = `req_addr[log2(LINE_WIDTH/8) +: log2(DEPTH)]`. Upper address bits are ignored, so addresses alias modulo the store size. Low offset bits are dropped: `rsp_addr` has them zeroed.
- Reset (reset=0, asynchronous): state returns to IDLE, the counter clears, and `rsp_valid`/`rsp_id`/`rsp_addr`/`rsp_data`/`busy` all go to 0. Store contents are not reset.
- States:
  - IDLE: when `req_read|req_write` is seen at a posedge, capture id, addr, data and op into holding registers and load the counter with LATENCY-1. Go to WAIT if LATENCY>1, otherwise directly to RESPOND. `busy`=1 from the next cycle.
  - WAIT: decrement the counter each cycle. At 0, go to RESPOND. Request inputs are ignored; the holding registers are authoritative.
  - RESPOND: a single cycle.
    - `rsp_valid`=1, with `rsp_id` and `rsp_addr` from the holding registers.
    - Write: the store line is written at this posedge and `rsp_data` = captured data.
    - Read: `rsp_data` = the store line.
    - Next state is COOLDOWN.
  - COOLDOWN: one cycle with `rsp_valid`=0 and requests ignored, giving the master one cycle to drop its held request. Then go to IDLE.
- Latency: a request first seen at posedge T gives `rsp_valid` high during the cycle after posedge T+LATENCY. The next request can be accepted at posedge T+LATENCY+2 at the earliest.
- `req_read` and `req_write` both high: treated as a write. The response carries the written data.
- A read of a line written by a previous transaction returns the new data; there is no stale window.
- `rsp_data`, `rsp_id` and `rsp_addr` hold their last values when `rsp_valid`=0. The master must qualify them with `rsp_valid`.
- Reset asserted in WAIT or RESPOND before the write posedge: the transaction is aborted, no response is issued, and the store is not modified.
- A request deasserted early by the master during WAIT is still completed, and the response is still issued.
- The request sequence is arbitrated upstream; this block does not reorder and never has more than one transaction in flight.

Test Plan:
- Reset to 0 mid-WAIT with a read pending → all outputs go to 0 immediately (asynchronous), no `rsp_valid` follows, FSM is in IDLE once reset=1.
- LATENCY=4: write id=0, addr=0x0000_0010, data=0x1111…1111, held until valid → `rsp_valid` 1 cycle, 4 cycles after acceptance, rsp_id=0, rsp_addr=0x10, rsp_data=0x1111…1111; busy falls 2 cycles later.
- Read id=1, addr=0x0000_001C after the above → rsp_id=1, rsp_addr=0x10 (aligned), rsp_data=0x1111…1111.
- DEPTH=256, LINE_WIDTH=128: write 0xAAAA… to addr 0x0000_1020, then read 0x0000_0020 → returns 0xAAAA… (alias).
- read=1 and write=1 simultaneously, data=0x55…55, addr 0x40 → treated as a write; a subsequent read of 0x40 returns 0x55…55.
- LATENCY=1, back-to-back held requests → response 1 cycle after acceptance, cooldown cycle honoured, second request accepted exactly 3 cycles after the first; no double response.
